// File: rtl/shift_register_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : shift_register_serializer
//  Description : Parallel-in, serial-out front end for a serial-in shift
//                register. Accepts a WIDTH-bit word over valid/ready and
//                emits it one bit per clock, MSB-first or LSB-first, with a
//                downstream hold, optional inter-word gap and a one-cycle
//                frame_done pulse after the last bit of every word.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH      word width in bits (2..32)
//    GAP        idle cycles forced between words (0..15)
//  Ports
//    clk        rising-edge clock
//    rst        synchronous, active-high reset
//    in_data    parallel word to serialize
//    in_valid   in_data is valid
//    in_ready   a word can be accepted this cycle
//    lsb_first  bit order (1 = LSB first), sampled only at accept
//    hold       downstream stall, freezes shifting
//    ser_d      serial data bit (to shift register d)
//    ser_en     ser_d valid this cycle (to shift register en)
//    frame_done one-cycle pulse after the last bit of a word
//    busy       high whenever the block is not idle
// ============================================================================
module shift_register_serializer #(
   parameter int WIDTH = 4,
   parameter int GAP   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             lsb_first,
   input  logic             hold,
   output logic             ser_d,
   output logic             ser_en,
   output logic             frame_done,
   output logic             busy
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   // Final value of the gap counter; unused when GAP is zero.
   localparam logic [3:0]       GAP_LAST = 4'((GAP > 0) ? (GAP - 1) : 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             lsb_q, lsb_d;
   logic [3:0]       gap_q, gap_d;
   logic             frame_done_q, frame_done_d;

   logic             last_bit;
   logic             accept;

   // The final bit of a word leaves the block in this cycle.
   assign last_bit = (state_q == ST_SHIFT) && !hold && (cnt_q == LAST_CNT);

   // With no gap the last-bit cycle doubles as an accept slot, giving
   // bubble-free back-to-back words.
   assign in_ready = !rst && ((state_q == ST_IDLE) || (last_bit && (GAP == 0)));
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      data_d       = data_q;
      lsb_d        = lsb_q;
      gap_d        = gap_q;
      frame_done_d = last_bit;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               data_d  = in_data;
               lsb_d   = lsb_first;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            if (!hold) begin
               // Move the next bit to the active end of the register.
               data_d = lsb_q ? (data_q >> 1) : (data_q << 1);
               cnt_d  = cnt_q + 1'b1;
               if (last_bit) begin
                  if (accept) begin
                     data_d  = in_data;
                     lsb_d   = lsb_first;
                     cnt_d   = '0;
                     state_d = ST_SHIFT;
                  end else if (GAP > 0) begin
                     gap_d   = '0;
                     state_d = ST_GAP;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
         end

         ST_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         data_q       <= '0;
         lsb_q        <= 1'b0;
         gap_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         data_q       <= data_d;
         lsb_q        <= lsb_d;
         gap_q        <= gap_d;
         frame_done_q <= frame_done_d;
      end
   end

   // ser_d comes only from registers; hold leaves it on the current bit.
   assign ser_d      = (state_q == ST_SHIFT) ? (lsb_q ? data_q[0] : data_q[WIDTH-1]) : 1'b0;
   assign ser_en     = (state_q == ST_SHIFT) && !hold;
   assign busy       = (state_q != ST_IDLE);
   assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_register_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_register_serializer
//  Description : Self-checking bench for shift_register_serializer. Two
//                instances (GAP=0 and GAP=2) share stimulus; a bit-list
//                reference model per instance is compared every cycle, and
//                directed sequences pin the model with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_register_serializer;

   localparam int K_EN = 0, K_RDY = 1, K_FD = 2, K_BUSY = 3, K_D = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       lsb_first;
   logic       hold;
   logic [3:0] in_data;
   logic [1:0] in_ready_v, ser_d_v, ser_en_v, fd_v, busy_v;

   always #5 clk = ~clk;

   shift_register_serializer #(.WIDTH(4), .GAP(0)) u_dut_g0 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready_v[0]), .lsb_first(lsb_first), .hold(hold),
      .ser_d(ser_d_v[0]), .ser_en(ser_en_v[0]), .frame_done(fd_v[0]),
      .busy(busy_v[0]));

   shift_register_serializer #(.WIDTH(4), .GAP(2)) u_dut_g2 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready_v[1]), .lsb_first(lsb_first), .hold(hold),
      .ser_d(ser_d_v[1]), .ser_en(ser_en_v[1]), .frame_done(fd_v[1]),
      .busy(busy_v[1]));

   int n_cmp = 0;
   int n_err = 0;
   bit started = 1'b0;

   // Reference model: 0 idle, 1 emitting bits, 2 gap.
   int phase[2]    = '{0, 0};
   bit ord[2][4];
   int pos[2]      = '{0, 0};
   int gap_left[2] = '{0, 0};
   bit fd_m[2]     = '{1'b0, 1'b0};

   // Per-cycle history of the model's expectations.
   bit lg_en[2][64], lg_rdy[2][64], lg_fd[2][64], lg_busy[2][64], lg_d[2][64];
   int lg_n[2]  = '{0, 0};
   int lg_dn[2] = '{0, 0};

   function automatic int gapv(input int g);
      return (g == 0) ? 0 : 2;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pk(input int kind, input int g, input int from, input int len);
      logic [31:0] r;
      bit b;
      r = '0;
      for (int i = 0; i < len; i++) begin
         case (kind)
            K_EN:    b = lg_en[g][from+i];
            K_RDY:   b = lg_rdy[g][from+i];
            K_FD:    b = lg_fd[g][from+i];
            K_BUSY:  b = lg_busy[g][from+i];
            default: b = lg_d[g][from+i];
         endcase
         r = {r[30:0], b};
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (started) begin
         for (int g = 0; g < 2; g++) begin
            bit e_last, e_rdy, e_en, e_busy, acc;
            e_last = (phase[g] == 1) && !hold && (pos[g] == 3);
            e_rdy  = !rst && ((phase[g] == 0) || (e_last && gapv(g) == 0));
            e_en   = (phase[g] == 1) && !hold;
            e_busy = (phase[g] != 0);

            chk($sformatf("in_ready[%0d]", g), {31'd0, in_ready_v[g]}, {31'd0, e_rdy});
            chk($sformatf("ser_en[%0d]", g), {31'd0, ser_en_v[g]}, {31'd0, e_en});
            chk($sformatf("busy[%0d]", g), {31'd0, busy_v[g]}, {31'd0, e_busy});
            chk($sformatf("frame_done[%0d]", g), {31'd0, fd_v[g]}, {31'd0, fd_m[g]});
            if (phase[g] == 1)
               chk($sformatf("ser_d[%0d]", g), {31'd0, ser_d_v[g]}, {31'd0, ord[g][pos[g]]});

            if (lg_n[g] < 64) begin
               lg_en[g][lg_n[g]]   = e_en;
               lg_rdy[g][lg_n[g]]  = e_rdy;
               lg_fd[g][lg_n[g]]   = fd_m[g];
               lg_busy[g][lg_n[g]] = e_busy;
               lg_n[g]++;
            end
            if (e_en && lg_dn[g] < 64) begin
               lg_d[g][lg_dn[g]] = ord[g][pos[g]];
               lg_dn[g]++;
            end

            acc = in_valid && e_rdy;
            if (rst) begin
               phase[g] = 0;
               fd_m[g]  = 1'b0;
            end else begin
               fd_m[g] = e_last;
               if (phase[g] == 1 && !hold) begin
                  pos[g]++;
                  if (pos[g] == 4) begin
                     if (gapv(g) > 0) begin
                        phase[g]    = 2;
                        gap_left[g] = gapv(g);
                     end else begin
                        phase[g] = 0;
                     end
                  end
               end else if (phase[g] == 2) begin
                  gap_left[g]--;
                  if (gap_left[g] == 0) phase[g] = 0;
               end
               if (acc) begin
                  for (int i = 0; i < 4; i++)
                     ord[g][i] = lsb_first ? in_data[i] : in_data[3-i];
                  pos[g]   = 0;
                  phase[g] = 1;
               end
            end
         end
      end
   end

   task automatic step(input bit v, input logic [3:0] d, input bit l, input bit h, input bit r);
      in_valid  = v;
      in_data   = d;
      lsb_first = l;
      hold      = h;
      rst       = r;
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      lg_n  = '{0, 0};
      lg_dn = '{0, 0};
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; lsb_first = 1'b0; hold = 1'b0;
      @(posedge clk);
      #1;
      started = 1'b1;
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      idle(3);

      // MSB-first 1011
      clr();
      step(1'b1, 4'b1011, 1'b0, 1'b0, 1'b0);
      idle(6);
      chk("t1 nbits", lg_dn[0], 4);
      chk("t1 bits", pk(K_D, 0, 0, 4), 32'b1011);
      chk("t1 fd", pk(K_FD, 0, 0, 7), 32'b0000010);
      chk("t1 busy", pk(K_BUSY, 0, 0, 7), 32'b0111100);

      // LSB-first 1011, lsb_first toggled mid-frame
      clr();
      step(1'b1, 4'b1011, 1'b1, 1'b0, 1'b0);
      step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      chk("t2 bits", pk(K_D, 0, 0, 4), 32'b1101);

      // hold at N+2, N+3
      clr();
      step(1'b1, 4'b1100, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      idle(4);
      chk("t3 en", pk(K_EN, 0, 0, 8), 32'b01001110);
      chk("t3 bits", pk(K_D, 0, 0, 4), 32'b1100);
      chk("t3 fd", pk(K_FD, 0, 0, 8), 32'b00000001);

      // back-to-back A then 5, valid held high
      clr();
      for (int i = 0; i < 4; i++) step(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
      idle(5);
      chk("t4 bits", pk(K_D, 0, 0, 8), 32'b10100101);
      chk("t4 en", pk(K_EN, 0, 1, 8), 32'hFF);
      chk("t4 rdy", pk(K_RDY, 0, 0, 10), 32'b1000100011);
      chk("t4 fd", pk(K_FD, 0, 0, 10), 32'b0000010001);

      // GAP=2 instance, back-to-back words
      clr();
      step(1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) step(1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
      idle(8);
      chk("t5 rdy", pk(K_RDY, 1, 4, 4), 32'b0001);
      chk("t5 en", pk(K_EN, 1, 5, 4), 32'b0001);
      chk("t5 bits", pk(K_D, 1, 0, 8), 32'b10010011);

      // reset mid-frame
      clr();
      step(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      chk("t6 rdy", pk(K_RDY, 0, 2, 3), 32'b001);
      chk("t6 en", pk(K_EN, 0, 3, 1), 32'b0);
      chk("t6 busy", pk(K_BUSY, 0, 4, 1), 32'b0);
      chk("t6 fd", pk(K_FD, 0, 0, 5), 32'b0);
      clr();
      step(1'b1, 4'b0110, 1'b1, 1'b0, 1'b0);
      idle(6);
      chk("t6 bits", pk(K_D, 0, 0, 4), 32'b0110);
      chk("t6 fd2", pk(K_FD, 0, 0, 7), 32'b0000010);

      // randomized traffic
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 3) != 0, 4'($urandom), 1'($urandom),
              $urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0);
      idle(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
